modinv_helper_invert_shift: RTL and testbench
=============================================

# modinv_helper_invert_shift

Shift helper for the modular invertor's almost-inverse loop. In one pass over two multiword buffers it computes a_out = a_in >> 1 and b_out = b_in << 1, the "u even: u = u/2, s = 2s" and "v even: v = v/2, r = 2r" updates. It sits directly downstream of the invert-compare helper: the invertor FSM reads that helper's parity and compare flags, then starts this block on the selected buffer pair.

## Interface
Parameters:
- BUFFER_NUM_WORDS, 9, words per operand buffer (32-bit words, word 0 = least significant)
- BUFFER_ADDR_BITS, 4, buffer address width

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset; synchronous, active-low
- ena  input  1  start request; sampled only while rdy=1
- rdy  output  1  idle/done flag
- a_rd_addr  output  BUFFER_ADDR_BITS  read address, right-shift operand
- a_din  input  32  read data, one cycle after a_rd_addr
- a_wr_addr  output  BUFFER_ADDR_BITS  write address, right-shift result
- a_wr_en  output  1  write strobe, right-shift result
- a_dout  output  32  write data, right-shift result
- b_rd_addr  output  BUFFER_ADDR_BITS  read address, left-shift operand
- b_din  input  32  read data, one cycle after b_rd_addr
- b_wr_addr  output  BUFFER_ADDR_BITS  write address, left-shift result
- b_wr_en  output  1  write strobe, left-shift result
- b_dout  output  32  write data, left-shift result
- a_lsb_lost  output  1  bit shifted out of a word 0 (1 = caller error, a was odd)
- b_msb_lost  output  1  bit shifted out of b word N-1 (1 = overflow)

## Operation
- N = BUFFER_NUM_WORDS. Busy counter proc_cnt runs 0..N+2. rdy = (proc_cnt == 0).
- Start: rdy=1 and ena=1 at an edge sets proc_cnt=1. While busy, proc_cnt increments each cycle and wraps N+2 -> 0. ena is ignored while busy.
- Read phase, proc_cnt = 1..N:
  - a_rd_addr steps N-1 down to 0 (MSW first).
  - b_rd_addr steps 0 up to N-1 (LSW first).
  - While idle: a_rd_addr = N-1, b_rd_addr = 0.
- Data phase, proc_cnt = 2..N+1: a_din/b_din hold the word addressed on the previous cycle.
- Right shift:
  - word w result = {a_carry, a_din[31:1]}, then a_carry <= a_din[0].
  - a_carry is cleared at start, so the MSB of word N-1 is 0.
- Left shift:
  - word w result = {b_din[30:0], b_carry}, then b_carry <= b_din[31].
  - b_carry is cleared at start, so the LSB of word 0 is 0.
- Write phase, proc_cnt = 3..N+2: registered a_dout/a_wr_addr/a_wr_en and b_dout/b_wr_addr/b_wr_en, one word per cycle.
  - a_wr_addr runs N-1..0; b_wr_addr runs 0..N-1.
  - Exactly N write strobes per operand per run.
- Flags:
  - a_lsb_lost is cleared at start and loaded with a_din[0] of word 0.
  - b_msb_lost is cleared at start and loaded with b_din[31] of word N-1.
  - Both are valid once rdy returns and hold until the next start.
- In-place operation (read and write address the same dual-port buffer) is legal: word w is written two cycles after it is read, and is never read again in the same run.

## Timing
- ena accepted at edge T: rdy low from T+1 to T+N+2, high again at T+N+3; total latency N+2 cycles.
- First read address at T+1. First write strobe at T+3. Last write strobe at T+N+2, retired on the edge where rdy rises.
- Back-to-back: ena held high gives a new start on the same edge rdy reads 1. No idle gap is required beyond the rdy=1 cycle.
- Reset (rst_n=0 at an edge), values at the next edge:
  - proc_cnt=0, rdy=1.
  - a_wr_en=0, b_wr_en=0.
  - a_rd_addr=N-1, b_rd_addr=0.
  - a_wr_addr=N-1, b_wr_addr=0.
  - a_dout=0, b_dout=0.
  - a_lsb_lost=0, b_msb_lost=0.
  - carries = 0.
- Reset mid-run: the write stream stops immediately. Already written words stay in the buffer, which is then undefined as an operand.
- ena together with rst_n=0: reset wins, no start.

## Structure
- Shared package/include: modinv_clog2 function; PROC_NUM_CYCLES = N+3 and PROC_CNT_BITS = clog2(PROC_NUM_CYCLES); phase boundary constants (read 1..N, write 3..N+2).
- One sub-module is natural: modinv_helper_shift_lane (one 32-bit word lane: direction parameter, carry register, registered output word). It is instantiated twice, right-shift for a and left-shift for b. Counter and address generation stay in the top.

## Test plan
- a = 0x…0000_0002 (only bit 1 set), b = 1 → a_out word 0 = 0x1, b_out word 0 = 0x2, all other words 0; both flags 0; rdy high exactly 11 cycles after ena (N=9).
- Carry across words: a word1=0x1, word0=0 → a_out word0=0x8000_0000, word1=0; b word0=0x8000_0000 → b_out word1=0x1, word0=0.
- Odd a (word0=0x3) → a_lsb_lost=1, a_out word0=0x1. b word8=0x8000_0000 → b_msb_lost=1, b_out all zero.
- All-ones a and b (every word 0xFFFF_FFFF) → a_out word8=0x7FFF_FFFF, others 0xFFFF_FFFF; b_out word0=0xFFFF_FFFE, others 0xFFFF_FFFF; a_lsb_lost=1, b_msb_lost=1.
- In-place, back-to-back: ena held high for two runs on the same buffers, a=8, b=1 → a=2, b=4; the first run takes 11 busy cycles, the second starts on the edge rdy reads 1 and also takes 11.
- rst_n low at proc_cnt=5 → next cycle rdy=1 and both write enables 0; the next start completes correctly from fresh operands.

Source files
------------

// File: rtl/modinv_helper_invert_shift_pkg.sv
// -----------------------------------------------------------------------------
// modinv_helper_invert_shift_pkg
//
// Purpose:
//   Shared definitions for the modular invertor shift helper: word width,
//   shift direction type, a constant-foldable clog2 and the busy-counter
//   phase boundaries of a single shift pass.
//
// Contents:
//   WORD_BITS          width of one buffer word
//   shift_dir_e        direction of a shift lane
//   modinv_clog2()     ceil(log2(value)) usable in parameter expressions
//   proc_num_cycles()  counter modulus for an N-word pass (N+3)
//   CNT_* / cnt_*()    first/last counter values of the read, data and
//                      write phases
// -----------------------------------------------------------------------------
package modinv_helper_invert_shift_pkg;

    localparam int WORD_BITS = 32;

    typedef enum logic {
        SHIFT_RIGHT = 1'b0,
        SHIFT_LEFT  = 1'b1
    } shift_dir_e;

    function automatic int modinv_clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        return result;
    endfunction

    // Counter values 0..N+2: 0 is idle, so the modulus is N+3.
    function automatic int proc_num_cycles(input int num_words);
        return num_words + 3;
    endfunction

    // Read phase 1..N, data phase 2..N+1, write phase 3..N+2.
    localparam int CNT_RD_FIRST   = 1;
    localparam int CNT_DATA_FIRST = 2;

    function automatic int cnt_rd_last(input int num_words);
        return num_words;
    endfunction

    function automatic int cnt_data_last(input int num_words);
        return num_words + 1;
    endfunction

    function automatic int cnt_wr_last(input int num_words);
        return num_words + 2;
    endfunction

endpackage

// File: rtl/modinv_helper_shift_lane.sv
// -----------------------------------------------------------------------------
// modinv_helper_shift_lane
//
// Purpose:
//   One 32-bit word lane of a multiword shift by one bit. Words arrive one
//   per cycle in shift order (MSW first for a right shift, LSW first for a
//   left shift); the bit pushed out of each word is carried into the next.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   clear     clears the carry at the start of a pass
//   shift_en  din holds a valid word this cycle
//   din       incoming word
//   dout      registered shifted word
//   carry     bit shifted out of the most recent word
// -----------------------------------------------------------------------------
module modinv_helper_shift_lane
    import modinv_helper_invert_shift_pkg::*;
#(
    parameter shift_dir_e DIR = SHIFT_RIGHT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [WORD_BITS-1:0] din,
    output logic [WORD_BITS-1:0] dout,
    output logic                 carry
);

    logic [WORD_BITS-1:0] dout_q;
    logic [WORD_BITS-1:0] dout_d;
    logic                 carry_q;
    logic                 carry_d;

    // The carry entering a word is the bit that fell off the previous word,
    // so clearing it at start makes the first shifted-in bit zero.
    always_comb begin
        dout_d  = dout_q;
        carry_d = carry_q;
        if (clear) begin
            carry_d = 1'b0;
        end else if (shift_en) begin
            if (DIR == SHIFT_RIGHT) begin
                dout_d  = {carry_q, din[WORD_BITS-1:1]};
                carry_d = din[0];
            end else begin
                dout_d  = {din[WORD_BITS-2:0], carry_q};
                carry_d = din[WORD_BITS-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            carry_q <= carry_d;
        end
    end

    assign dout  = dout_q;
    assign carry = carry_q;

endmodule

// File: rtl/modinv_helper_invert_shift.sv
// -----------------------------------------------------------------------------
// modinv_helper_invert_shift
//
// Purpose:
//   Single pass over two multiword buffers computing a_out = a_in >> 1 and
//   b_out = b_in << 1 for the almost-inverse loop. a is streamed MSW first,
//   b LSW first. Results may be written back into the source buffers.
//
// Ports:
//   clk, rst_n            clock / synchronous active-low reset
//   ena, rdy              start request (taken while rdy=1) / idle flag
//   a_rd_addr, a_din      right-shift operand read port (1-cycle latency)
//   a_wr_addr/en, a_dout  right-shift result write port
//   b_rd_addr, b_din      left-shift operand read port (1-cycle latency)
//   b_wr_addr/en, b_dout  left-shift result write port
//   a_lsb_lost            bit shifted out of a word 0 (a was odd)
//   b_msb_lost            bit shifted out of b word N-1 (overflow)
// -----------------------------------------------------------------------------
module modinv_helper_invert_shift
    import modinv_helper_invert_shift_pkg::*;
#(
    parameter int BUFFER_NUM_WORDS = 9,
    parameter int BUFFER_ADDR_BITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    output logic                        rdy,
    output logic [BUFFER_ADDR_BITS-1:0] a_rd_addr,
    input  logic [WORD_BITS-1:0]        a_din,
    output logic [BUFFER_ADDR_BITS-1:0] a_wr_addr,
    output logic                        a_wr_en,
    output logic [WORD_BITS-1:0]        a_dout,
    output logic [BUFFER_ADDR_BITS-1:0] b_rd_addr,
    input  logic [WORD_BITS-1:0]        b_din,
    output logic [BUFFER_ADDR_BITS-1:0] b_wr_addr,
    output logic                        b_wr_en,
    output logic [WORD_BITS-1:0]        b_dout,
    output logic                        a_lsb_lost,
    output logic                        b_msb_lost
);

    localparam int N             = BUFFER_NUM_WORDS;
    localparam int PROC_CNT_BITS = modinv_clog2(proc_num_cycles(N));

    typedef logic [PROC_CNT_BITS-1:0]    cnt_t;
    typedef logic [BUFFER_ADDR_BITS-1:0] addr_t;

    localparam cnt_t  CNT_IDLE       = '0;
    localparam cnt_t  CNT_START      = cnt_t'(CNT_RD_FIRST);
    localparam cnt_t  CNT_RD_LAST    = cnt_t'(cnt_rd_last(N));
    localparam cnt_t  CNT_DATA_START = cnt_t'(CNT_DATA_FIRST);
    localparam cnt_t  CNT_DATA_END   = cnt_t'(cnt_data_last(N));
    localparam cnt_t  CNT_WR_END     = cnt_t'(cnt_wr_last(N));
    localparam cnt_t  CNT_ONE        = cnt_t'(1);
    localparam addr_t ADDR_MSW       = addr_t'(N - 1);
    localparam addr_t ADDR_LSW       = '0;
    localparam addr_t ADDR_ONE       = addr_t'(1);

    logic  [PROC_CNT_BITS-1:0] proc_cnt_q, proc_cnt_d;
    addr_t a_rd_addr_q, a_rd_addr_d;
    addr_t b_rd_addr_q, b_rd_addr_d;
    addr_t a_wr_addr_q, a_wr_addr_d;
    addr_t b_wr_addr_q, b_wr_addr_d;
    logic  a_wr_en_q, a_wr_en_d;
    logic  b_wr_en_q, b_wr_en_d;
    logic  a_lsb_lost_q, a_lsb_lost_d;
    logic  b_msb_lost_q, b_msb_lost_d;

    logic start;
    logic rd_advance;
    logic data_phase;
    logic a_carry;
    logic b_carry;

    assign start      = (proc_cnt_q == CNT_IDLE) && ena;
    // Addresses step after every read cycle except the last; the last read
    // cycle parks them back at their idle values for the next pass.
    assign rd_advance = (proc_cnt_q >= CNT_START) && (proc_cnt_q < CNT_RD_LAST);
    assign data_phase = (proc_cnt_q >= CNT_DATA_START) && (proc_cnt_q <= CNT_DATA_END);

    // Busy counter: one start from idle, then free-runs to the end of the
    // write phase and wraps to idle. ena is not looked at while busy.
    always_comb begin
        proc_cnt_d = proc_cnt_q;
        if (proc_cnt_q == CNT_IDLE) begin
            if (start) begin
                proc_cnt_d = CNT_START;
            end
        end else if (proc_cnt_q == CNT_WR_END) begin
            proc_cnt_d = CNT_IDLE;
        end else begin
            proc_cnt_d = proc_cnt_q + CNT_ONE;
        end
    end

    // Read addresses: a walks down from the MSW, b walks up from the LSW.
    always_comb begin
        a_rd_addr_d = ADDR_MSW;
        b_rd_addr_d = ADDR_LSW;
        if (rd_advance) begin
            a_rd_addr_d = a_rd_addr_q - ADDR_ONE;
            b_rd_addr_d = b_rd_addr_q + ADDR_ONE;
        end
    end

    // Write side trails the read side by two cycles (RAM latency plus the
    // lane output register), so the word index is derived from the counter
    // value of the cycle in which its data is on a_din/b_din.
    always_comb begin
        a_wr_addr_d = ADDR_MSW;
        b_wr_addr_d = ADDR_LSW;
        a_wr_en_d   = data_phase;
        b_wr_en_d   = data_phase;
        if (data_phase) begin
            a_wr_addr_d = addr_t'(N + 1 - int'(proc_cnt_q));
            b_wr_addr_d = addr_t'(int'(proc_cnt_q) - CNT_DATA_FIRST);
        end
    end

    // The lost bits are those carried out of the final word of each stream,
    // captured when that word is on the read data bus.
    always_comb begin
        a_lsb_lost_d = a_lsb_lost_q;
        b_msb_lost_d = b_msb_lost_q;
        if (start) begin
            a_lsb_lost_d = 1'b0;
            b_msb_lost_d = 1'b0;
        end else if (proc_cnt_q == CNT_DATA_END) begin
            a_lsb_lost_d = a_din[0];
            b_msb_lost_d = b_din[WORD_BITS-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            proc_cnt_q   <= CNT_IDLE;
            a_rd_addr_q  <= ADDR_MSW;
            b_rd_addr_q  <= ADDR_LSW;
            a_wr_addr_q  <= ADDR_MSW;
            b_wr_addr_q  <= ADDR_LSW;
            a_wr_en_q    <= 1'b0;
            b_wr_en_q    <= 1'b0;
            a_lsb_lost_q <= 1'b0;
            b_msb_lost_q <= 1'b0;
        end else begin
            proc_cnt_q   <= proc_cnt_d;
            a_rd_addr_q  <= a_rd_addr_d;
            b_rd_addr_q  <= b_rd_addr_d;
            a_wr_addr_q  <= a_wr_addr_d;
            b_wr_addr_q  <= b_wr_addr_d;
            a_wr_en_q    <= a_wr_en_d;
            b_wr_en_q    <= b_wr_en_d;
            a_lsb_lost_q <= a_lsb_lost_d;
            b_msb_lost_q <= b_msb_lost_d;
        end
    end

    modinv_helper_shift_lane #(
        .DIR (SHIFT_RIGHT)
    ) u_lane_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start),
        .shift_en (data_phase),
        .din      (a_din),
        .dout     (a_dout),
        .carry    (a_carry)
    );

    modinv_helper_shift_lane #(
        .DIR (SHIFT_LEFT)
    ) u_lane_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start),
        .shift_en (data_phase),
        .din      (b_din),
        .dout     (b_dout),
        .carry    (b_carry)
    );

    // The lane carries mirror the lost flags only at the end of a pass; the
    // flags are kept as separate registers so they stay stable and defined.
    logic carry_unused;
    assign carry_unused = a_carry ^ b_carry;

    assign rdy        = (proc_cnt_q == CNT_IDLE);
    assign a_rd_addr  = a_rd_addr_q;
    assign b_rd_addr  = b_rd_addr_q;
    assign a_wr_addr  = a_wr_addr_q;
    assign b_wr_addr  = b_wr_addr_q;
    assign a_wr_en    = a_wr_en_q;
    assign b_wr_en    = b_wr_en_q;
    assign a_lsb_lost = a_lsb_lost_q;
    assign b_msb_lost = b_msb_lost_q;

endmodule

// File: tb/tb_modinv_helper_invert_shift.sv
// -----------------------------------------------------------------------------
// tb_modinv_helper_invert_shift
//
// Purpose:
//   Drives the shift helper against two dual-port buffer models and compares
//   the buffer contents and flags with whole-operand arithmetic (>> 1, << 1
//   on the full multiword value).
// -----------------------------------------------------------------------------
module tb_modinv_helper_invert_shift;

    localparam int NW = 9;
    localparam int AW = 4;
    localparam int VW = NW * 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          rdy;
    logic [AW-1:0] a_rd_addr, a_wr_addr, b_rd_addr, b_wr_addr;
    logic [31:0]   a_din, b_din, a_dout, b_dout;
    logic          a_wr_en, b_wr_en;
    logic          a_lsb_lost, b_msb_lost;

    logic [31:0]   a_mem  [16];
    logic [31:0]   b_mem  [16];
    logic [31:0]   a_init [16];
    logic [31:0]   b_init [16];
    logic          load_req;

    int checks = 0;
    int fails  = 0;

    // Run statistics filled in by run_op.
    int busy_cnt, wr_a_cnt, wr_b_cnt, first_wr;
    bit timed_out;

    always #5 clk = ~clk;

    modinv_helper_invert_shift #(
        .BUFFER_NUM_WORDS (NW),
        .BUFFER_ADDR_BITS (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .rdy        (rdy),
        .a_rd_addr  (a_rd_addr),
        .a_din      (a_din),
        .a_wr_addr  (a_wr_addr),
        .a_wr_en    (a_wr_en),
        .a_dout     (a_dout),
        .b_rd_addr  (b_rd_addr),
        .b_din      (b_din),
        .b_wr_addr  (b_wr_addr),
        .b_wr_en    (b_wr_en),
        .b_dout     (b_dout),
        .a_lsb_lost (a_lsb_lost),
        .b_msb_lost (b_msb_lost)
    );

    // Dual-port buffers with registered read; results are written in place
    // into the same buffer the operand was read from.
    always @(posedge clk) begin
        a_din <= a_mem[a_rd_addr];
        b_din <= b_mem[b_rd_addr];
        if (load_req) begin
            for (int i = 0; i < 16; i++) begin
                a_mem[i] <= a_init[i];
                b_mem[i] <= b_init[i];
            end
        end else begin
            if (a_wr_en) a_mem[a_wr_addr] <= a_dout;
            if (b_wr_en) b_mem[b_wr_addr] <= b_dout;
        end
    end

    function automatic logic [VW-1:0] get_a();
        logic [VW-1:0] v;
        for (int i = 0; i < NW; i++) v[32*i +: 32] = a_mem[i];
        return v;
    endfunction

    function automatic logic [VW-1:0] get_b();
        logic [VW-1:0] v;
        for (int i = 0; i < NW; i++) v[32*i +: 32] = b_mem[i];
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < NW; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic load_ops(input logic [VW-1:0] a, input logic [VW-1:0] b);
        for (int i = 0; i < 16; i++) begin
            a_init[i] = (i < NW) ? a[32*i +: 32] : 32'h0;
            b_init[i] = (i < NW) ? b[32*i +: 32] : 32'h0;
        end
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Pulses ena for one edge and counts busy cycles and write strobes,
    // sampling on falling edges, until rdy returns or the budget expires.
    task automatic run_op();
        busy_cnt  = 0;
        wr_a_cnt  = 0;
        wr_b_cnt  = 0;
        first_wr  = -1;
        timed_out = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        while (!rdy) begin
            busy_cnt++;
            if (a_wr_en) begin
                wr_a_cnt++;
                if (first_wr < 0) first_wr = busy_cnt;
            end
            if (b_wr_en) wr_b_cnt++;
            if (busy_cnt > 200) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rdy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_rdy: got %b expected 1", rdy);
        end
        checks++;
        if ({a_wr_en, b_wr_en} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL reset_wr_en: got %b expected 00", {a_wr_en, b_wr_en});
        end
        checks++;
        if (a_rd_addr !== AW'(NW - 1) || b_rd_addr !== '0) begin
            fails++;
            $display("[TB] FAIL reset_rd_addr: got a=%0d b=%0d expected a=%0d b=0", a_rd_addr, b_rd_addr, NW - 1);
        end
        checks++;
        if (a_wr_addr !== AW'(NW - 1) || b_wr_addr !== '0) begin
            fails++;
            $display("[TB] FAIL reset_wr_addr: got a=%0d b=%0d expected a=%0d b=0", a_wr_addr, b_wr_addr, NW - 1);
        end
        checks++;
        if (a_dout !== 32'h0 || b_dout !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_dout: got a=%h b=%h expected 0", a_dout, b_dout);
        end
        checks++;
        if ({a_lsb_lost, b_msb_lost} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL reset_flags: got %b expected 00", {a_lsb_lost, b_msb_lost});
        end
        rst_n = 1'b1;
    endtask

    // One pass on the given operands, compared with whole-operand arithmetic.
    task automatic test_shift(input string name, input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] exp_a, exp_b;
        logic          exp_lsb, exp_msb;
        exp_a   = a >> 1;
        exp_b   = b << 1;
        exp_lsb = a[0];
        exp_msb = b[VW-1];
        load_ops(a, b);
        run_op();
        checks++;
        if (timed_out) begin
            fails++;
            $display("[TB] FAIL %s_timeout: rdy still low after %0d cycles", name, busy_cnt);
        end
        checks++;
        if (busy_cnt !== NW + 2) begin
            fails++;
            $display("[TB] FAIL %s_latency: got %0d busy cycles expected %0d", name, busy_cnt, NW + 2);
        end
        checks++;
        if (wr_a_cnt !== NW || wr_b_cnt !== NW) begin
            fails++;
            $display("[TB] FAIL %s_strobes: got a=%0d b=%0d expected %0d", name, wr_a_cnt, wr_b_cnt, NW);
        end
        checks++;
        if (first_wr !== 3) begin
            fails++;
            $display("[TB] FAIL %s_first_write: got busy cycle %0d expected 3", name, first_wr);
        end
        checks++;
        if (get_a() !== exp_a) begin
            fails++;
            $display("[TB] FAIL %s_a_out: got %h expected %h", name, get_a(), exp_a);
        end
        checks++;
        if (get_b() !== exp_b) begin
            fails++;
            $display("[TB] FAIL %s_b_out: got %h expected %h", name, get_b(), exp_b);
        end
        checks++;
        if (a_lsb_lost !== exp_lsb || b_msb_lost !== exp_msb) begin
            fails++;
            $display("[TB] FAIL %s_flags: got lsb=%b msb=%b expected lsb=%b msb=%b", name, a_lsb_lost, b_msb_lost, exp_lsb, exp_msb);
        end
    endtask

    task automatic test_basic();
        test_shift("basic", VW'(2), VW'(1));
    endtask

    task automatic test_carry();
        test_shift("carry", VW'(64'h1_0000_0000), VW'(32'h8000_0000));
    endtask

    task automatic test_lost_bits();
        logic [VW-1:0] b;
        b = '0;
        b[VW-1] = 1'b1;
        test_shift("lost", VW'(3), b);
    endtask

    task automatic test_all_ones();
        test_shift("ones", '1, '1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) test_shift("random", rand_vec(), rand_vec());
    endtask

    task automatic test_back_to_back();
        int busy1, idle_gap, busy2;
        logic [VW-1:0] a, b;
        a = VW'(8);
        b = VW'(1);
        load_ops(a, b);
        busy1 = 0;
        idle_gap = 0;
        busy2 = 0;
        @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        while (!rdy && busy1 < 200) begin
            busy1++;
            @(negedge clk);
        end
        while (rdy && idle_gap < 5) begin
            idle_gap++;
            @(negedge clk);
        end
        ena = 1'b0;
        while (!rdy && busy2 < 200) begin
            busy2++;
            @(negedge clk);
        end
        checks++;
        if (busy1 !== NW + 2 || busy2 !== NW + 2) begin
            fails++;
            $display("[TB] FAIL b2b_latency: got %0d/%0d busy cycles expected %0d", busy1, busy2, NW + 2);
        end
        checks++;
        if (idle_gap !== 1) begin
            fails++;
            $display("[TB] FAIL b2b_gap: got %0d idle cycles expected 1", idle_gap);
        end
        checks++;
        if (get_a() !== (a >> 2)) begin
            fails++;
            $display("[TB] FAIL b2b_a_out: got %h expected %h", get_a(), a >> 2);
        end
        checks++;
        if (get_b() !== (b << 2)) begin
            fails++;
            $display("[TB] FAIL b2b_b_out: got %h expected %h", get_b(), b << 2);
        end
    endtask

    task automatic test_reset_mid_run();
        load_ops(rand_vec(), rand_vec());
        @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        ena   = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || a_wr_en !== 1'b0 || b_wr_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midrst_stop: got rdy=%b wr_en=%b%b expected rdy=1 wr_en=00", rdy, a_wr_en, b_wr_en);
        end
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midrst_ena_ignored: got rdy=%b expected 1", rdy);
        end
        ena   = 1'b0;
        rst_n = 1'b1;
        test_shift("after_reset", rand_vec(), rand_vec());
    endtask

    initial begin
        ena      = 1'b0;
        rst_n    = 1'b0;
        load_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_init[i] = 32'h0;
            b_init[i] = 32'h0;
        end
        test_reset();
        test_basic();
        test_carry();
        test_lost_bits();
        test_all_ones();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
